// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package cache_pkg;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int OFFSET_W    = $clog2(BLOCK_BYTES);
  localparam int INDEX_W     = $clog2(NUM_BLOCKS);
  localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } cache_state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
    return a[OFFSET_W-1:0];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty/tag/data per line, combinational reads,
// registered byte and metadata writes. Valid and dirty clear on reset.
module dcache_array
  import cache_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [INDEX_W-1:0]                   rd_index,
  input  logic [OFFSET_W-1:0]                  rd_offset,
  output logic                                 rd_valid,
  output logic                                 rd_dirty,
  output logic [TAG_W-1:0]                     rd_tag,
  output logic [BLOCK_BYTES-1:0][DATA_W-1:0]   rd_line,
  output logic [DATA_W-1:0]                    rd_byte,
  input  logic                                 wr_en,
  input  logic [INDEX_W-1:0]                   wr_index,
  input  logic [OFFSET_W-1:0]                  wr_offset,
  input  logic [DATA_W-1:0]                    wr_byte,
  input  logic                                 meta_en,
  input  logic [INDEX_W-1:0]                   meta_index,
  input  logic                                 meta_valid,
  input  logic                                 meta_dirty,
  input  logic [TAG_W-1:0]                     meta_tag
);

  logic [NUM_BLOCKS-1:0]                              valid_q, valid_d;
  logic [NUM_BLOCKS-1:0]                              dirty_q, dirty_d;
  logic [NUM_BLOCKS-1:0][TAG_W-1:0]                   tag_q, tag_d;
  logic [NUM_BLOCKS-1:0][BLOCK_BYTES-1:0][DATA_W-1:0] data_q, data_d;

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];
  assign rd_byte  = data_q[rd_index][rd_offset];

  // Next-state of the storage: apply at most one byte write and one metadata write.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      data_d[wr_index][wr_offset] = wr_byte;
    end
    if (meta_en) begin
      valid_d[meta_index] = meta_valid;
      dirty_d[meta_index] = meta_dirty;
      tag_d[meta_index]   = meta_tag;
    end
  end

  // Storage registers; only valid/dirty need clearing, tag and data are don't-care when invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate byte cache controller.
// Holds the miss FSM, the beat counter and the hit compare; storage lives in dcache_array.
//
// Memory beat handshake: the controller raises mem_read or mem_write together with
// mem_address (and mem_writedata) and holds them. A beat completes at the first posedge
// where the strobe was already high on the previous posedge and mem_busywait is low.
// After each completion the strobe drops for exactly one gap cycle so the memory can
// re-arm its busy detection before the next beat.
module dcache_controller
  import cache_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [ADDR_W-1:0]  address,
  input  logic [DATA_W-1:0]  writedata,
  output logic [DATA_W-1:0]  readdata,
  output logic               busywait,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [DATA_W-1:0]  mem_writedata,
  input  logic [DATA_W-1:0]  mem_readdata,
  input  logic               mem_busywait,
  output cache_state_e       dbg_state
);

  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(BLOCK_BYTES - 1);

  cache_state_e         state_q, state_d;
  logic [OFFSET_W-1:0]  beat_q, beat_d;
  logic [INDEX_W-1:0]   index_q, index_d;
  logic [TAG_W-1:0]     victim_tag_q, victim_tag_d;
  logic                 armed_q, armed_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]    mem_address_q, mem_address_d;
  logic [DATA_W-1:0]    mem_writedata_q, mem_writedata_d;

  logic [TAG_W-1:0]                    req_tag;
  logic [INDEX_W-1:0]                  req_index;
  logic [OFFSET_W-1:0]                 req_offset;
  logic                                req_valid;
  logic [INDEX_W-1:0]                  line_index;
  logic                                rd_valid, rd_dirty;
  logic [TAG_W-1:0]                    rd_tag;
  logic [BLOCK_BYTES-1:0][DATA_W-1:0]  rd_line;
  logic [DATA_W-1:0]                   rd_byte;
  logic                                hit, strobe_q, beat_done;

  logic                 wr_en, meta_en, meta_dirty;
  logic [INDEX_W-1:0]   wr_index, meta_index;
  logic [OFFSET_W-1:0]  wr_offset;
  logic [DATA_W-1:0]    wr_byte;

  assign req_tag    = addr_tag(address);
  assign req_index  = addr_index(address);
  assign req_offset = addr_offset(address);
  // Simultaneous read and write is illegal and behaves as no request.
  assign req_valid  = read ^ write;
  assign line_index = (state_q == IDLE) ? req_index : index_q;
  assign hit        = rd_valid && (rd_tag == req_tag);
  assign strobe_q   = mem_read_q | mem_write_q;
  assign beat_done  = strobe_q && armed_q && !mem_busywait;

  assign busywait      = !reset && ((state_q != IDLE) || (req_valid && !hit));
  assign readdata      = (!reset && state_q == IDLE && read && !write && hit) ? rd_byte : '0;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;
  assign dbg_state     = state_q;

  dcache_array u_array (
    .clk        (clock),
    .reset      (reset),
    .rd_index   (line_index),
    .rd_offset  (req_offset),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .rd_byte    (rd_byte),
    .wr_en      (wr_en),
    .wr_index   (wr_index),
    .wr_offset  (wr_offset),
    .wr_byte    (wr_byte),
    .meta_en    (meta_en),
    .meta_index (meta_index),
    .meta_valid (1'b1),
    .meta_dirty (meta_dirty),
    .meta_tag   (req_tag)
  );

  // Next state, beat sequencing, registered memory strobes and array write controls.
  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    index_d         = index_q;
    victim_tag_d    = victim_tag_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    wr_en           = 1'b0;
    wr_index        = line_index;
    wr_offset       = req_offset;
    wr_byte         = writedata;
    meta_en         = 1'b0;
    meta_index      = line_index;
    meta_dirty      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && !hit) begin
          index_d      = req_index;
          victim_tag_d = rd_tag;
          beat_d       = '0;
          if (rd_valid && rd_dirty) begin
            state_d         = WRITEBACK;
            mem_write_d     = 1'b1;
            mem_address_d   = {rd_tag, req_index, {OFFSET_W{1'b0}}};
            mem_writedata_d = rd_line[0];
          end else begin
            state_d       = FETCH;
            mem_read_d    = 1'b1;
            mem_address_d = {req_tag, req_index, {OFFSET_W{1'b0}}};
          end
        end else if (write && !read && hit) begin
          wr_en      = 1'b1;
          meta_en    = 1'b1;
          meta_dirty = 1'b1;
        end
      end
      WRITEBACK: begin
        if (!strobe_q) begin
          mem_write_d     = 1'b1;
          mem_address_d   = {victim_tag_q, index_q, beat_q};
          mem_writedata_d = rd_line[beat_q];
        end else if (beat_done) begin
          mem_write_d = 1'b0;
          beat_d      = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (!strobe_q) begin
          mem_read_d    = 1'b1;
          mem_address_d = {req_tag, index_q, beat_q};
        end else if (beat_done) begin
          mem_read_d = 1'b0;
          wr_en      = 1'b1;
          wr_index   = index_q;
          wr_offset  = beat_q;
          wr_byte    = mem_readdata;
          beat_d     = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            meta_en    = 1'b1;
            meta_index = index_q;
            meta_dirty = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase

    // A beat is armed once its strobe has been seen high on a previous edge.
    armed_d = strobe_q && (mem_read_d || mem_write_d);

    if (reset) begin
      wr_en   = 1'b0;
      meta_en = 1'b0;
    end
  end

  // FSM, beat counter and registered memory-side outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      beat_q          <= '0;
      index_q         <= '0;
      victim_tag_q    <= '0;
      armed_q         <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      index_q         <= index_d;
      victim_tag_q    <= victim_tag_d;
      armed_q         <= armed_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a byte memory model and a beat log scoreboard.
module tb_dcache_controller;
  import cache_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         read, write;
  logic [7:0]   address, writedata, readdata;
  logic         busywait;
  logic         mem_read, mem_write;
  logic [7:0]   mem_address, mem_writedata, mem_readdata;
  logic         mem_busywait;
  cache_state_e dbg_state;

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  dcache_controller dut (
    .clock         (clk),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait),
    .dbg_state     (dbg_state)
  );

  // ---------------- memory model ----------------
  // Busy for the first 'lat' strobe cycles of every beat; a beat completes on an edge
  // where the strobe was high on the previous edge too and busy is low.
  logic [7:0]  mem_arr [256];
  int          lat = 1;
  int          busy_cnt = 0;
  bit          strobe_prev = 1'b0;
  int          cyc = 0;
  logic [16:0] exp_q [$];
  logic [16:0] got_q [$];
  int          stamp_q [$];

  assign mem_readdata = mem_arr[mem_address];
  assign mem_busywait = (mem_read || mem_write) && (busy_cnt < lat);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_read || mem_write) busy_cnt <= busy_cnt + 1;
    else busy_cnt <= 0;
    strobe_prev <= mem_read || mem_write;
    if ((mem_read || mem_write) && strobe_prev && !mem_busywait) begin
      got_q.push_back({mem_write, mem_address, mem_write ? mem_writedata : mem_readdata});
      stamp_q.push_back(cyc);
      if (mem_write) mem_arr[mem_address] <= mem_writedata;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_beat(input logic is_wr, input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({is_wr, a, d});
  endtask

  // Compares the logged memory beats against exp_q, then the spacing of completions.
  task automatic check_log(input string tag, input int gap);
    logic [16:0] e, g;
    check({tag, " beat count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, " beat"}, 32'(g), 32'(e));
    end
    if (gap > 0) begin
      for (int i = 1; i < stamp_q.size(); i++) begin
        check({tag, " beat spacing"}, 32'(stamp_q[i] - stamp_q[i-1]), 32'(gap));
      end
    end
    exp_q.delete();
    got_q.delete();
    stamp_q.delete();
  endtask

  // ---------------- driver ----------------
  // Presents a request at a negedge, counts stall cycles, returns readdata on the serving cycle.
  task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                        output int stall, output logic [7:0] rdata);
    @(negedge clk);
    read = rd; write = wr; address = a; writedata = wd;
    #1;
    stall = 0;
    while (busywait && stall < 200) begin
      stall++;
      @(negedge clk);
      #1;
    end
    rdata = readdata;
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         stall;
    int         n;
    logic [7:0] rd;

    for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i) ^ 8'h5C;
    reset = 1'b1; read = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;

    // Reset values, with a would-be miss presented to show reset masks busywait.
    repeat (2) @(negedge clk);
    read = 1'b1; address = 8'h10;
    #1;
    check("reset busywait", 32'(busywait), 32'd0);
    check("reset readdata", 32'(readdata), 32'd0);
    check("reset mem_read", 32'(mem_read), 32'd0);
    check("reset mem_write", 32'(mem_write), 32'd0);
    check("reset mem_address", 32'(mem_address), 32'd0);
    check("reset mem_writedata", 32'(mem_writedata), 32'd0);
    check("reset state", 32'(dbg_state), 32'(IDLE));
    read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("post-reset busywait", 32'(busywait), 32'd0);
    check("post-reset mem_read", 32'(mem_read), 32'd0);

    // Clean read miss on 0x10.
    access(1'b1, 1'b0, 8'h10, 8'h00, stall, rd);
    check("clean miss stall", 32'(stall), 32'd12);
    check("clean miss data", 32'(rd), 32'h4C);
    expect_beat(1'b0, 8'h10, 8'h4C); expect_beat(1'b0, 8'h11, 8'h4D);
    expect_beat(1'b0, 8'h12, 8'h4E); expect_beat(1'b0, 8'h13, 8'h4F);
    check_log("clean miss", 3);

    // Write hit then read hit.
    access(1'b0, 1'b1, 8'h11, 8'h5A, stall, rd);
    check("write hit stall", 32'(stall), 32'd0);
    check_log("write hit", 0);
    access(1'b1, 1'b0, 8'h11, 8'h00, stall, rd);
    check("read hit stall", 32'(stall), 32'd0);
    check("read hit data", 32'(rd), 32'h5A);

    // Dirty victim on index 4.
    access(1'b1, 1'b0, 8'h31, 8'h00, stall, rd);
    check("dirty miss stall", 32'(stall), 32'd24);
    check("dirty miss data", 32'(rd), 32'h6D);
    expect_beat(1'b1, 8'h10, 8'h4C); expect_beat(1'b1, 8'h11, 8'h5A);
    expect_beat(1'b1, 8'h12, 8'h4E); expect_beat(1'b1, 8'h13, 8'h4F);
    expect_beat(1'b0, 8'h30, 8'h6C); expect_beat(1'b0, 8'h31, 8'h6D);
    expect_beat(1'b0, 8'h32, 8'h6E); expect_beat(1'b0, 8'h33, 8'h6F);
    check_log("dirty miss", 3);
    check("writeback landed", 32'(mem_arr[8'h11]), 32'h5A);

    // Illegal read+write acts as idle even though 0x10 would now miss.
    access(1'b1, 1'b1, 8'h10, 8'hEE, stall, rd);
    check("illegal stall", 32'(stall), 32'd0);
    check("illegal readdata", 32'(rd), 32'd0);
    check_log("illegal", 0);

    // Store clean miss allocates, then the store lands.
    access(1'b0, 1'b1, 8'h44, 8'hC3, stall, rd);
    check("store miss stall", 32'(stall), 32'd12);
    expect_beat(1'b0, 8'h44, 8'h18); expect_beat(1'b0, 8'h45, 8'h19);
    expect_beat(1'b0, 8'h46, 8'h1A); expect_beat(1'b0, 8'h47, 8'h1B);
    check_log("store miss", 3);
    access(1'b1, 1'b0, 8'h44, 8'h00, stall, rd);
    check("store readback", 32'(rd), 32'hC3);
    check("store readback stall", 32'(stall), 32'd0);
    access(1'b1, 1'b0, 8'h45, 8'h00, stall, rd);
    check("neighbour byte", 32'(rd), 32'h19);

    // Eviction of the stored line writes the new byte back.
    access(1'b1, 1'b0, 8'h64, 8'h00, stall, rd);
    check("evict stall", 32'(stall), 32'd24);
    check("evict data", 32'(rd), 32'h38);
    expect_beat(1'b1, 8'h44, 8'hC3); expect_beat(1'b1, 8'h45, 8'h19);
    expect_beat(1'b1, 8'h46, 8'h1A); expect_beat(1'b1, 8'h47, 8'h1B);
    expect_beat(1'b0, 8'h64, 8'h38); expect_beat(1'b0, 8'h65, 8'h39);
    expect_beat(1'b0, 8'h66, 8'h3A); expect_beat(1'b0, 8'h67, 8'h3B);
    check_log("evict", 3);
    check("evicted byte in memory", 32'(mem_arr[8'h44]), 32'hC3);

    // Reset during FETCH beat 2.
    @(negedge clk);
    read = 1'b1; address = 8'h84;
    n = 0;
    while (got_q.size() < 2 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!mem_read && n < 100) begin @(negedge clk); n++; end
    check("beat2 strobe", 32'(mem_read), 32'd1);
    check("beat2 address", 32'(mem_address), 32'h86);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("abort mem_read", 32'(mem_read), 32'd0);
    check("abort mem_write", 32'(mem_write), 32'd0);
    check("abort busywait", 32'(busywait), 32'd0);
    check("abort state", 32'(dbg_state), 32'(IDLE));
    read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    expect_beat(1'b0, 8'h84, 8'hD8); expect_beat(1'b0, 8'h85, 8'hD9);
    check_log("aborted fetch", 3);
    access(1'b1, 1'b0, 8'h84, 8'h00, stall, rd);
    check("re-read stall", 32'(stall), 32'd12);
    check("re-read data", 32'(rd), 32'hD8);
    expect_beat(1'b0, 8'h84, 8'hD8); expect_beat(1'b0, 8'h85, 8'hD9);
    expect_beat(1'b0, 8'h86, 8'hDA); expect_beat(1'b0, 8'h87, 8'hDB);
    check_log("re-read", 3);

    // Slow memory: busy for 3 extra cycles per beat.
    lat = 4;
    access(1'b1, 1'b0, 8'hA6, 8'h00, stall, rd);
    check("slow clean stall", 32'(stall), 32'd24);
    check("slow clean data", 32'(rd), 32'hFA);
    expect_beat(1'b0, 8'hA4, 8'hF8); expect_beat(1'b0, 8'hA5, 8'hF9);
    expect_beat(1'b0, 8'hA6, 8'hFA); expect_beat(1'b0, 8'hA7, 8'hFB);
    check_log("slow clean", 6);
    access(1'b0, 1'b1, 8'hA5, 8'h77, stall, rd);
    check("slow write hit stall", 32'(stall), 32'd0);
    access(1'b1, 1'b0, 8'hC4, 8'h00, stall, rd);
    check("slow dirty stall", 32'(stall), 32'd48);
    check("slow dirty data", 32'(rd), 32'h98);
    expect_beat(1'b1, 8'hA4, 8'hF8); expect_beat(1'b1, 8'hA5, 8'h77);
    expect_beat(1'b1, 8'hA6, 8'hFA); expect_beat(1'b1, 8'hA7, 8'hFB);
    expect_beat(1'b0, 8'hC4, 8'h98); expect_beat(1'b0, 8'hC5, 8'h99);
    expect_beat(1'b0, 8'hC6, 8'h9A); expect_beat(1'b0, 8'hC7, 8'h9B);
    check_log("slow dirty", 6);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate byte cache between the CPU load/store port and the 256×8 `data_memory`. It serves hits with zero stall. On a miss it stalls the CPU with `busywait` and sequences byte transfers to `data_memory` through that memory's read/write/busywait handshake: first a 4-byte write-back if the victim is dirty, then a 4-byte fetch.

## Interface
- NUM_BLOCKS, 8, cache lines; power of two.
- BLOCK_BYTES, 4, bytes per line; power of two.
- Address split for the defaults: tag = address[7:5], index = address[4:2], offset = address[1:0].
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- read  in  1  CPU load request.
- write  in  1  CPU store request. read && write is illegal and treated as idle.
- address  in  8  CPU byte address.
- writedata  in  8  CPU store data.
- readdata  out  8  CPU load data; valid when read && !busywait.
- busywait  out  1  CPU stall; combinational.
- mem_read  out  1  memory read strobe; registered.
- mem_write  out  1  memory write strobe; registered.
- mem_address  out  8  memory byte address; registered.
- mem_writedata  out  8  memory write data; registered.
- mem_readdata  in  8  memory read data.
- mem_busywait  in  1  memory busy.

## Operation
- Per-line state: valid, dirty, tag[2:0], data[4][8].
- Hit: valid[index] && tag[index] == address tag.
- FSM has three states: IDLE, WRITEBACK, FETCH.
- IDLE, read hit:
  - readdata = data[index][offset], combinational.
  - busywait = 0.
- IDLE, write hit:
  - busywait = 0.
  - At the posedge: data[index][offset] <= writedata, dirty <= 1.
- IDLE, miss (read or write):
  - busywait = 1 combinationally in the same cycle.
  - Next state is WRITEBACK if valid && dirty, else FETCH.
  - Latch victim tag, index and beat = 0.
- WRITEBACK:
  - 4 beats, mem_write = 1.
  - mem_address = {victim tag, index, beat}.
  - mem_writedata = data[index][beat].
  - After beat 3 → FETCH.
- FETCH:
  - 4 beats, mem_read = 1.
  - mem_address = {request tag, index, beat}.
  - On each beat completion: data[index][beat] <= mem_readdata.
  - After beat 3: valid <= 1, dirty <= 0, tag <= request tag; → IDLE.
- Back in IDLE the held request is a hit and is served by the hit path. A store therefore sets dirty only after allocation.
- Beat protocol:
  - Strobe and address are asserted and held.
  - The beat completes at the first posedge where the strobe was also asserted on the previous posedge and mem_busywait == 0.
  - The strobe is then deasserted for exactly one gap cycle before the next beat. The gap re-arms the memory's busy detection.
- busywait = 1 in every cycle the FSM is not IDLE, and in IDLE on a miss.
- CPU address, read, write and writedata must be held stable while busywait = 1. The controller does not latch the request tag beyond the FSM entry.

## Timing
- Reset values, synchronous, while reset = 1 and on the first cycle after:
  - FSM IDLE.
  - All valid = 0, all dirty = 0.
  - mem_read = mem_write = 0, mem_address = 0, mem_writedata = 0.
  - busywait = 0 (reset overrides the miss term).
  - readdata = 0.
- Reset mid-miss aborts the sequence. Memory may hold a partially written-back block; the cache line stays invalid.
- Latency against a memory that completes one edge after the strobe:
  - Each beat is 2 strobe cycles plus 1 gap.
  - Clean miss: busywait high for 12 cycles; the request is served on the 13th.
  - Dirty miss: busywait high for 24 cycles; the request is served on the 25th.
- Hits: 0 stall cycles.
- Beat counter is 2 bits and wraps 3 → 0 on each phase exit.
- A memory that holds mem_busywait high extends each beat indefinitely. There is no timeout.

## Structure
- Shared package `cache_pkg`:
  - FSM state encoding (IDLE, WRITEBACK, FETCH).
  - TAG_W, INDEX_W, OFFSET_W, NUM_BLOCKS, BLOCK_BYTES.
- Sub-module `dcache_array`:
  - valid/dirty/tag/data storage with synchronous clear on reset.
  - Combinational read of line (index) and byte (index, offset).
  - Registered byte write and metadata write.
- The controller holds only the FSM, the beat counter and the hit compare.

## Test plan
- After reset, read 0x10 → miss. Expect:
  - busywait high for 12 cycles.
  - mem_read at addresses 0x10 to 0x13 in order, one gap cycle between beats.
  - Then readdata = memory[0x10], busywait 0.
- Write 0x5A to 0x11 (now a hit) → busywait stays 0, no memory strobe. Read 0x11 returns 0x5A.
- Read 0x31, which has the same index and a dirty victim. Expect:
  - mem_write to 0x10–0x13, with 0x5A at 0x11.
  - Then mem_read 0x30–0x33.
  - busywait high for 24 cycles.
- Write to 0x44 with a clean miss → fetch 0x44–0x47, then the store is applied. A later eviction writes the new byte back.
- Assert reset during FETCH beat 2. Expect:
  - All mem strobes low the next cycle, busywait 0.
  - A re-read of the same address misses again.
- Memory model holds mem_busywait for 3 extra cycles per beat → data is still correct and the beat order is unchanged.
